fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Computes the EX-stage operand forwarding selects one cycle early, at ID, and registers them, so the 3:1 operand muxes see a glitch-free flop output.
- Generates load-use stalls, branch flushes and whole-pipe freeze.
- Keeps its own shadow tag pipeline (EX/MEM/WB) and saturating performance counters.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, perf counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_W  ID source 1 index
- id_rs2  in  REG_W  ID source 2 index
- id_rd  in  REG_W  ID destination index
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_stall_req  in  1  data memory not ready; freeze pipe
- fwd_a_sel  out  2  EX operand A mux select (00 regfile, 01 WB result, 10 MEM ALU result)
- fwd_b_sel  out  2  EX operand B mux select, same encoding
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- flush_id  out  1  clear IF/ID register
- flush_ex  out  1  load bubble into ID/EX
- perf_stall_cnt  out  CNT_W  cycles lost to load-use plus freeze
- perf_flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst_n=0 at posedge): all tags invalid, fwd_*_sel=00, counters=0, FSM=RUN.
- Reset mid-stall: next cycle is RUN with no bubble.
- Shadow tags: t_ex, t_mem, t_wb = {valid, rd, we, load}.
  - On advance: t_wb<=t_mem; t_mem<=t_ex; t_ex<=ID tag (or invalid on bubble/flush).
  - A tag matches only if valid & we & rd!=0.
- Forwarding, per source rs, computed at ID, registered on advance (latency 1, aligned with ID/EX):
  - 10 if rs matches t_ex.
  - else 01 if rs matches t_mem.
  - else 00.
  - The younger producer wins.
  - The WB-stage producer at EX time needs no forward: the regfile is write-through.
  - On a bubble or flush, the registered sel is 00.
- Load-use: id_valid and (rs1 or rs2) matches t_ex with load=1.
  - Outputs: stall_if=stall_id=1, flush_ex=1 for exactly 1 cycle.
  - The next cycle re-evaluates against the shifted tags and forwards 01.
- Branch: ex_branch_taken gives flush_id=flush_ex=1 for 1 cycle. The ID tag does not enter t_ex.
- Priority: mem_stall_req > ex_branch_taken > load-use.
  - A branch coincident with load-use gives a flush only, no stall.
- Freeze (mem_stall_req=1):
  - Outputs: stall_if=stall_id=freeze=1.
  - Tags and fwd_*_sel hold; flush outputs are 0.
  - A pending branch/load-use is evaluated when the freeze deasserts, since the inputs are then still present.
- FSM states:
  - RUN: advance.
  - LU_STALL: one bubble cycle, auto-returns to RUN.
  - FREEZE: held while mem_stall_req=1, returns to RUN.
  - Transitions are taken combinationally from the state priority above; outputs are Mealy on the current inputs.
- Counters:
  - perf_stall_cnt increments on each LU_STALL or FREEZE cycle.
  - perf_flush_cnt increments on each flush cycle.
  - Both saturate at all-ones with no wrap.
- Outputs stall_if/stall_id/freeze/flush_* are combinational from registered state plus current inputs. fwd_*_sel are registered.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - the tag struct/field widths
  - FSM state encodings RUN/LU_STALL/FREEZE
- One sub-module: sat_counter (width param, inc, rst_n), instantiated twice.

Test Plan:
- Reset with rst_n=0 for 2 cycles, mid-freeze -> all sel 00, counters 0, no stall/flush on the first RUN cycle.
- ADD x5 then SUB x6,x5,x1 back-to-back -> fwd_a_sel=10 on the SUB's EX cycle, no stall.
- ADD x5; NOP; OR x7,x0,x5 -> fwd_b_sel=01. Retest with rd=x0 -> 00.
- LW x3 then ADD x4,x3,x3 -> one cycle of stall_if=stall_id=flush_ex=1, then fwd_a_sel=fwd_b_sel=01; perf_stall_cnt=1.
- Taken branch in EX coincident with load-use at ID -> flush_id=flush_ex=1, no stall; perf_flush_cnt=1, perf_stall_cnt unchanged.
- mem_stall_req high for 3 cycles during a forward chain -> freeze=1 for 3 cycles, sels held, perf_stall_cnt+=3. Forced counter at all-ones -> stays all-ones.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// shadow-tag layout and FSM state encodings.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int TAG_RD_W = 5;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                we;
        logic                load;
    } tag_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_e;

    // x0 is hard-wired, so a write to it never produces a forwardable value.
    function automatic logic tag_match(input tag_t t, input logic [TAG_RD_W-1:0] rs);
        return t.valid && t.we && (t.rd != '0) && (t.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [TAG_RD_W-1:0] rs,
                                           input tag_t ex, input tag_t mem);
        if (tag_match(ex, rs))
            return FWD_MEM;
        else if (tag_match(mem, rs))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_branch_taken;
    logic             mem_stall_req;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall_if;
    logic             stall_id;
    logic             freeze;
    logic             flush_id;
    logic             flush_ex;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               ex_branch_taken, mem_stall_req,
        input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, freeze, flush_id, flush_ex,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               ex_branch_taken, mem_stall_req,
        output fwd_a_sel, fwd_b_sel, stall_if, stall_id, freeze, flush_id, flush_ex,
               perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state is only ever written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= '0;
        else if (inc && (count_q != '1))
            count_q <= count_q + WIDTH'(1);
    end

    assign count = count_q;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Hazard controller: registered EX forwarding selects, load-use stall,
// branch flush and memory freeze, plus stall/flush performance counters.
module fwd_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = TAG_RD_W,
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    fwd_hazard_ctrl_if.slave  hz
);
    state_e     state_q, state_d;
    tag_t       t_ex_q, t_ex_d, t_mem_q;
    tag_t       id_tag;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [REG_W-1:0] rs1, rs2;
    logic       load_use, branch_flush, lu_stall, bubble;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rs1          = hz.id_rs1;
        rs2          = hz.id_rs2;
        id_tag       = '{valid: hz.id_valid, rd: hz.id_rd, we: hz.id_reg_write, load: hz.id_mem_read};
        load_use     = 1'b0;
        state_d      = RUN;
        branch_flush = 1'b0;

        if (hz.id_valid && (state_q != LU_STALL) && t_ex_q.load)
            load_use = tag_match(t_ex_q, rs1) || tag_match(t_ex_q, rs2);

        // Freeze dominates; a branch flush makes any load-use stall moot.
        if (hz.mem_stall_req)
            state_d = FREEZE;
        else if (hz.ex_branch_taken)
            branch_flush = 1'b1;
        else if (load_use)
            state_d = LU_STALL;

        lu_stall = (state_d == LU_STALL);
        bubble   = branch_flush || lu_stall || !hz.id_valid;
        t_ex_d   = bubble ? '0 : id_tag;
        fwd_a_d  = bubble ? FWD_RF : fwd_sel(rs1, t_ex_q, t_mem_q);
        fwd_b_d  = bubble ? FWD_RF : fwd_sel(rs2, t_ex_q, t_mem_q);
    end

    // A producer that has reached WB is covered by the write-through regfile,
    // so only the EX and MEM shadow tags are needed to pick a forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            t_ex_q  <= '0;
            t_mem_q <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            state_q <= state_d;
            if (!hz.mem_stall_req) begin
                t_mem_q <= t_ex_q;
                t_ex_q  <= t_ex_d;
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign hz.fwd_a_sel = fwd_a_q;
    assign hz.fwd_b_sel = fwd_b_q;
    assign hz.stall_if  = hz.mem_stall_req || lu_stall;
    assign hz.stall_id  = hz.mem_stall_req || lu_stall;
    assign hz.freeze    = hz.mem_stall_req;
    assign hz.flush_id  = branch_flush;
    assign hz.flush_ex  = branch_flush || lu_stall;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hz.mem_stall_req || lu_stall),
        .count (hz.perf_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch_flush),
        .count (hz.perf_flush_cnt)
    );
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding, load-use, branch, freeze,
// reset and counter saturation, with hand-computed expectations.
module tb_fwd_hazard_ctrl;
    logic clk;
    logic rst_n;
    logic sat_inc;
    logic [2:0] sat_count;
    int checks;
    int errors;

    fwd_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) hz ();

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    sat_counter #(.WIDTH(3)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sat_inc),
        .count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic ld);
        hz.id_valid     = v;
        hz.id_rs1       = rs1;
        hz.id_rs2       = rs2;
        hz.id_rd        = rd;
        hz.id_reg_write = we;
        hz.id_mem_read  = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        sat_inc = 1'b0;
        hz.ex_branch_taken = 1'b0;
        nop();

        // Reset held for two edges while a freeze is requested.
        hz.mem_stall_req = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_fwd_a", hz.fwd_a_sel, 32'd0);
        check("rst_fwd_b", hz.fwd_b_sel, 32'd0);
        check("rst_stall_cnt", hz.perf_stall_cnt, 32'd0);
        check("rst_flush_cnt", hz.perf_flush_cnt, 32'd0);
        check("rst_sat_cnt", sat_count, 32'd0);
        rst_n = 1'b1;
        hz.mem_stall_req = 1'b0;
        #1;
        check("rst_stall_if", hz.stall_if, 32'd0);
        check("rst_flush_ex", hz.flush_ex, 32'd0);
        check("rst_freeze", hz.freeze, 32'd0);
        tick();

        // ADD x5 ; SUB x6,x5,x1 -> MEM forward on operand A
        set_id(1, 5'd1, 5'd2, 5'd5, 1, 0);
        #1 check("add_stall_if", hz.stall_if, 32'd0);
        tick();
        set_id(1, 5'd5, 5'd1, 5'd6, 1, 0);
        #1 check("sub_stall_if", hz.stall_if, 32'd0);
        tick();
        check("ex_fwd_a", hz.fwd_a_sel, 32'd2);
        check("ex_fwd_b", hz.fwd_b_sel, 32'd0);
        nop(); tick(); tick();

        // Two writers of x8 in flight: the younger one wins
        set_id(1, 5'd1, 5'd2, 5'd8, 1, 0); tick();
        set_id(1, 5'd3, 5'd4, 5'd8, 1, 0); tick();
        set_id(1, 5'd8, 5'd8, 5'd9, 1, 0); tick();
        check("young_fwd_a", hz.fwd_a_sel, 32'd2);
        check("young_fwd_b", hz.fwd_b_sel, 32'd2);
        nop(); tick(); tick();

        // ADD x5 ; NOP ; OR x7,x0,x5 -> WB forward on operand B
        set_id(1, 5'd1, 5'd2, 5'd5, 1, 0); tick();
        nop(); tick();
        set_id(1, 5'd0, 5'd5, 5'd7, 1, 0); tick();
        check("mem_fwd_a", hz.fwd_a_sel, 32'd0);
        check("mem_fwd_b", hz.fwd_b_sel, 32'd1);

        // Same shape with rd=x0 -> nothing to forward
        set_id(1, 5'd1, 5'd2, 5'd0, 1, 0); tick();
        nop(); tick();
        set_id(1, 5'd0, 5'd0, 5'd7, 1, 0); tick();
        check("x0_fwd_a", hz.fwd_a_sel, 32'd0);
        check("x0_fwd_b", hz.fwd_b_sel, 32'd0);
        nop(); tick(); tick();

        // LW x3 ; ADD x4,x3,x3 -> one bubble, then WB forward on both operands
        set_id(1, 5'd1, 5'd0, 5'd3, 1, 1); tick();
        set_id(1, 5'd3, 5'd3, 5'd4, 1, 0);
        #1;
        check("lu_stall_if", hz.stall_if, 32'd1);
        check("lu_stall_id", hz.stall_id, 32'd1);
        check("lu_flush_ex", hz.flush_ex, 32'd1);
        check("lu_flush_id", hz.flush_id, 32'd0);
        check("lu_freeze", hz.freeze, 32'd0);
        tick();
        check("lu_bubble_fwd_a", hz.fwd_a_sel, 32'd0);
        check("lu_stall_cnt", hz.perf_stall_cnt, 32'd1);
        check("lu2_stall_if", hz.stall_if, 32'd0);
        check("lu2_flush_ex", hz.flush_ex, 32'd0);
        tick();
        check("lu2_fwd_a", hz.fwd_a_sel, 32'd1);
        check("lu2_fwd_b", hz.fwd_b_sel, 32'd1);
        check("lu2_stall_cnt", hz.perf_stall_cnt, 32'd1);
        nop(); tick(); tick();

        // Taken branch coincident with a load-use -> flush only
        set_id(1, 5'd1, 5'd0, 5'd3, 1, 1); tick();
        set_id(1, 5'd3, 5'd3, 5'd4, 1, 0);
        hz.ex_branch_taken = 1'b1;
        #1;
        check("br_flush_id", hz.flush_id, 32'd1);
        check("br_flush_ex", hz.flush_ex, 32'd1);
        check("br_stall_if", hz.stall_if, 32'd0);
        check("br_stall_id", hz.stall_id, 32'd0);
        tick();
        hz.ex_branch_taken = 1'b0;
        nop();
        check("br_flush_cnt", hz.perf_flush_cnt, 32'd1);
        check("br_stall_cnt", hz.perf_stall_cnt, 32'd1);
        check("br_fwd_a", hz.fwd_a_sel, 32'd0);
        tick(); tick();

        // Freeze for three cycles in the middle of a forward chain
        set_id(1, 5'd1, 5'd2, 5'd9, 1, 0); tick();
        set_id(1, 5'd9, 5'd9, 5'd10, 1, 0); tick();
        check("chain_fwd_a", hz.fwd_a_sel, 32'd2);
        check("chain_fwd_b", hz.fwd_b_sel, 32'd2);
        set_id(1, 5'd10, 5'd9, 5'd11, 1, 0);
        hz.mem_stall_req = 1'b1;
        #1;
        check("fz_freeze", hz.freeze, 32'd1);
        check("fz_stall_if", hz.stall_if, 32'd1);
        check("fz_stall_id", hz.stall_id, 32'd1);
        check("fz_flush_ex", hz.flush_ex, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_hold_a", hz.fwd_a_sel, 32'd2);
            check("fz_hold_b", hz.fwd_b_sel, 32'd2);
        end
        check("fz_stall_cnt", hz.perf_stall_cnt, 32'd4);
        hz.mem_stall_req = 1'b0;
        #1 check("fz_rel_freeze", hz.freeze, 32'd0);
        tick();
        check("fz_fwd_a", hz.fwd_a_sel, 32'd2);
        check("fz_fwd_b", hz.fwd_b_sel, 32'd1);
        check("fz_rel_stall_cnt", hz.perf_stall_cnt, 32'd4);

        // Branch arriving during a freeze is taken once the freeze drops
        nop();
        hz.mem_stall_req   = 1'b1;
        hz.ex_branch_taken = 1'b1;
        #1;
        check("pb_flush_id", hz.flush_id, 32'd0);
        check("pb_freeze", hz.freeze, 32'd1);
        tick();
        hz.mem_stall_req = 1'b0;
        #1 check("pb_rel_flush_id", hz.flush_id, 32'd1);
        tick();
        hz.ex_branch_taken = 1'b0;
        check("pb_flush_cnt", hz.perf_flush_cnt, 32'd2);
        check("pb_stall_cnt", hz.perf_stall_cnt, 32'd5);

        // Reset while frozen with live forwards clears everything
        set_id(1, 5'd1, 5'd2, 5'd12, 1, 0); tick();
        set_id(1, 5'd12, 5'd12, 5'd13, 1, 0); tick();
        check("rr_pre_fwd_a", hz.fwd_a_sel, 32'd2);
        hz.mem_stall_req = 1'b1;
        rst_n = 1'b0;
        tick();
        check("rr_fwd_a", hz.fwd_a_sel, 32'd0);
        check("rr_fwd_b", hz.fwd_b_sel, 32'd0);
        check("rr_stall_cnt", hz.perf_stall_cnt, 32'd0);
        check("rr_flush_cnt", hz.perf_flush_cnt, 32'd0);
        rst_n = 1'b1;
        hz.mem_stall_req = 1'b0;
        #1;
        check("rr_stall_if", hz.stall_if, 32'd0);
        check("rr_flush_ex", hz.flush_ex, 32'd0);
        tick();
        check("rr_run_fwd_a", hz.fwd_a_sel, 32'd0);

        // Narrow counter runs into all-ones and stays there
        nop();
        sat_inc = 1'b1;
        repeat (7) tick();
        check("sat_full", sat_count, 32'd7);
        repeat (3) tick();
        check("sat_hold", sat_count, 32'd7);
        sat_inc = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
